note_tone_tx: RTL

NOTE_TONE_TX -- requirements
Module: note_tone_tx

---
 rtl/note_tone_tx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/note_tone_tx.sv
// Queued square-wave note player: a 4-entry request FIFO feeds an IDLE/TONE/GAP
// controller that emits a signed square wave for each note, followed by a silent gap.
module note_tone_tx #(
  parameter int clk_mhz     = 50,
  parameter int tick_cycles = clk_mhz * 10000,
  parameter int gap_ticks   = 2,
  parameter int amp         = 8192
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic [3:0]         note_code,
  input  logic [1:0]         note_octave,
  input  logic [7:0]         note_len,
  output logic signed [15:0] sound,
  output logic               playing,
  output logic [11:0]        cur_note,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  typedef struct packed {
    logic [3:0] code;
    logic [1:0] oct;
    logic [7:0] len;
  } fifo_ent_t;

  function automatic logic [16:0] half_of(input int freq_100);
    logic [63:0] q;
    q = (64'(clk_mhz) * 64'd100000000) / (64'd2 * 64'(freq_100));
    return q[16:0];
  endfunction

  function automatic logic signed [15:0] sat_amp(input int a);
    if (a > 32767) return 16'sh7fff;
    if (a < 0)     return 16'sh0000;
    return $signed(16'(a));
  endfunction

  localparam logic [16:0] HALF_TAB [12] = '{
    half_of(26163), half_of(27718), half_of(29366), half_of(31113),
    half_of(32963), half_of(34923), half_of(36999), half_of(39200),
    half_of(41530), half_of(44000), half_of(46616), half_of(49388)
  };

  localparam int               TW        = (tick_cycles > 1) ? $clog2(tick_cycles) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(tick_cycles - 1);
  localparam logic [7:0]       GAP_LOAD  = 8'(gap_ticks);
  localparam logic             GAP_NONE  = (gap_ticks == 0);
  localparam logic signed [15:0] AMP_P   = sat_amp(amp);
  localparam logic signed [15:0] AMP_N   = -AMP_P;

  state_t          state_q, state_d;
  fifo_ent_t       mem_q [4];
  fifo_ent_t       mem_d [4];
  logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [7:0]      rem_q, rem_d;
  logic [16:0]     phase_q, phase_d;
  logic            pol_q, pol_d;
  logic            done_q, done_d;
  logic [16:0]     half_q, half_d;
  logic            rest_q, rest_d;
  logic [3:0]      code_q, code_d;

  logic            push, pop, tick_end;
  fifo_ent_t       head;
  logic [16:0]     head_base, head_half;
  logic [1:0]      head_shift;

  assign note_ready = (count_q != 3'd4);
  assign push       = note_valid & note_ready;
  assign pop        = (state_q == IDLE) && (count_q != 3'd0);
  assign tick_end   = (tick_q == TICK_LAST);

  assign head       = mem_q[rd_ptr_q];
  assign head_base  = (head.code < 4'd12) ? HALF_TAB[head.code] : 17'd0;
  assign head_shift = (head.oct == 2'd3) ? 2'd2 : head.oct;
  assign head_half  = head_base >> head_shift;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    if (push) mem_d[wr_ptr_q] = '{code: note_code, oct: note_octave, len: note_len};
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    pol_d   = pol_q;
    done_d  = 1'b0;
    half_d  = half_q;
    rest_d  = rest_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          // Every load restarts the wave and duration counters from zero.
          code_d  = head.code;
          rest_d  = (head.code >= 4'd12);
          half_d  = head_half;
          tick_d  = '0;
          phase_d = '0;
          pol_d   = 1'b0;
          if (head.len != 8'd0) begin
            state_d = TONE;
            rem_d   = head.len;
          end else if (GAP_NONE) begin
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            rem_d   = GAP_LOAD;
          end
        end
      end
      TONE: begin
        if (phase_q == half_q - 17'd1) begin
          phase_d = '0;
          pol_d   = ~pol_q;
        end else begin
          phase_d = phase_q + 17'd1;
        end
        if (tick_end) begin
          tick_d = '0;
          if (rem_q <= 8'd1) begin
            if (GAP_NONE) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
              rem_d   = GAP_LOAD;
            end
          end else begin
            rem_d = rem_q - 8'd1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      GAP: begin
        if (tick_end) begin
          tick_d = '0;
          if (rem_q <= 8'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - 8'd1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tick_q   <= '0;
      rem_q    <= '0;
      phase_q  <= '0;
      pol_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tick_q   <= tick_d;
      rem_q    <= rem_d;
      phase_q  <= phase_d;
      pol_q    <= pol_d;
      done_q   <= done_d;
    end
  end

  // Payload registers carry no reset; outputs only look at them while in TONE.
  always_ff @(posedge clk) begin
    mem_q  <= mem_d;
    half_q <= half_d;
    rest_q <= rest_d;
    code_q <= code_d;
  end

  assign playing  = (state_q == TONE);
  assign sound    = (playing && !rest_q) ? (pol_q ? AMP_N : AMP_P) : 16'sd0;
  assign cur_note = (playing && !rest_q) ? (12'h800 >> code_q) : 12'h000;
  assign done     = done_q;

endmodule
